ip4_axi_wr_mst: RTL

IP4_AXI_WR_MST -- requirements
Module: ip4_axi_wr_mst

---
 rtl/ip4_rtl_pkg.sv | 19 +
 rtl/ip4_outst_cnt.sv | 27 ++
 rtl/ip4_axi_wr_mst.sv | 112 +++++++++++
 3 files changed

// File: rtl/ip4_rtl_pkg.sv
// Shared AXI3 constants, BRESP encodings and the write-master state type.
package ip4_rtl_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 4;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] BRESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] BRESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] BRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} wr_state_e;

  // AXI size code = log2(bytes per beat).
  function automatic logic [AXI_SIZE_W-1:0] axi_size(input int data_w);
    return AXI_SIZE_W'($clog2(data_w / 8));
  endfunction
endpackage

// File: rtl/ip4_outst_cnt.sv
// Counts bursts whose B response is still pending; saturates at zero on a stray response.
module ip4_outst_cnt
  import ip4_rtl_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       full,
  output logic       underflow
);
  assign full      = (cnt >= 4'(MAX_OUTST));
  assign underflow = dec && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (inc && !dec) begin
      cnt <= cnt + 4'd1;
    end else if (dec && !inc && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/ip4_axi_wr_mst.sv
// AXI3 write master: one burst request in, AW beat then W beats out, B responses tracked.
module ip4_axi_wr_mst
  import ip4_rtl_pkg::*;
#(
  parameter int AXI_ID    = 0,
  parameter int WID_ADDR  = 32,
  parameter int WID_DATA  = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WID_ADDR-1:0]     req_addr,
  input  logic [3:0]              req_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [WID_DATA-1:0]     wd_data,
  input  logic [WID_DATA/8-1:0]   wd_strb,
  output logic [3:0]              awid,
  output logic [WID_ADDR-1:0]     awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [WID_DATA-1:0]     wdata,
  output logic [WID_DATA/8-1:0]   wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    err
);
  localparam int STRB_W = WID_DATA / 8;

  wr_state_e           state, state_nxt;
  logic [WID_ADDR-1:0] addr_q;
  logic [3:0]          len_q;
  logic [3:0]          beat_q;
  logic [3:0]          outst;
  logic                outst_full;
  logic                outst_underflow;
  logic                aw_hs, w_hs, b_hs;

  assign bready = 1'b1;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;

  assign awid   = 4'(AXI_ID);
  assign wid    = 4'(AXI_ID);
  assign awaddr = addr_q & ~WID_ADDR'(STRB_W - 1);
  assign awlen  = len_q;
  assign awsize = axi_size(WID_DATA);
  assign wdata  = wd_data;
  assign wstrb  = wd_strb;
  assign wlast  = (state == DATA) && (beat_q == len_q);

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) && !outst_full;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wd_ready  = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) state_nxt = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = DATA;
      end
      DATA: begin
        wvalid   = wd_valid;
        wd_ready = wready;
        if (wd_valid && wready && wlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/length are cleared by reset so the AW bus reads zero while held in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= 4'd0;
      beat_q <= 4'd0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      if (aw_hs) beat_q <= 4'd0;
      else if (w_hs) beat_q <= beat_q + 4'd1;
      if (outst_underflow || (b_hs && (bresp != BRESP_OKAY))) err <= 1'b1;
    end
  end

  ip4_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .clk       (clk),
    .rst       (rst),
    .inc       (aw_hs),
    .dec       (b_hs),
    .cnt       (outst),
    .full      (outst_full),
    .underflow (outst_underflow)
  );
endmodule
